// File: rtl/ysyx_25030093_pkg.sv
// Shared definitions for the ysyx_25030093 write-back stage: FSM encoding,
// default data width and CSR address width.
package ysyx_25030093_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CSR_AW     = 12;
  localparam int INSTRET_W  = 64;

  typedef logic [1:0] wbu_state_t;

  localparam wbu_state_t ST_IDLE   = 2'b00;
  localparam wbu_state_t ST_WRITE  = 2'b01;
  localparam wbu_state_t ST_COMMIT = 2'b10;

endpackage

// File: rtl/ysyx_25030093_instret_cnt.sv
// Retired-instruction counter; increments once per committed result and
// wraps naturally at 2^64.
module ysyx_25030093_instret_cnt
  import ysyx_25030093_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  output logic [INSTRET_W-1:0] cnt
);

  logic [INSTRET_W-1:0] cnt_q;
  logic [INSTRET_W-1:0] cnt_d;

  assign cnt_d = cnt_q + {{(INSTRET_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_25030093_wbu.sv
// Write-back unit: latches one execute result, issues GPR/CSR writes, then
// hands the next PC to fetch. Optional retire counter: YSYX_25030093_WBU_INSTRET_EN.
module ysyx_25030093_wbu
  import ysyx_25030093_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   next_pc,
  input  logic [RA_W-1:0]   rd_addr,
  input  logic              rd_wen,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic              csr_wen,
  output logic              gpr_wen,
  output logic [RA_W-1:0]   gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out
`ifdef YSYX_25030093_WBU_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  wbu_state_t        state_q, state_d;
  logic [XLEN-1:0]   rd_data_q, csr_wdata_q, next_pc_q;
  logic [RA_W-1:0]   rd_addr_q;
  logic              rd_wen_q;
  logic [CSR_AW-1:0] csr_addr_q;
  logic              csr_wen_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Anything outside the three legal encodings falls back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = in_fire ? ST_WRITE : ST_IDLE;
      ST_WRITE:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = out_ready ? ST_IDLE : ST_COMMIT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q   <= '0;
      csr_wdata_q <= '0;
      next_pc_q   <= '0;
      rd_addr_q   <= '0;
      rd_wen_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wen_q   <= 1'b0;
    end else if (in_fire) begin
      rd_data_q   <= rd_data;
      csr_wdata_q <= csr_wdata;
      next_pc_q   <= next_pc;
      rd_addr_q   <= rd_addr;
      rd_wen_q    <= rd_wen;
      csr_addr_q  <= csr_addr;
      csr_wen_q   <= csr_wen;
    end
  end

  // Outputs decode the state register directly so reset clears them at once.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_COMMIT);
  assign gpr_wen   = (state_q == ST_WRITE) & rd_wen_q & (|rd_addr_q);
  assign csr_we    = (state_q == ST_WRITE) & csr_wen_q;

  assign gpr_waddr = rd_addr_q;
  assign gpr_wdata = rd_data_q;
  assign csr_waddr = csr_addr_q;
  assign csr_wdat  = csr_wdata_q;
  assign pc_out    = next_pc_q;

`ifdef YSYX_25030093_WBU_INSTRET_EN
  ysyx_25030093_instret_cnt u_instret (
    .clock (clock),
    .reset (reset),
    .inc   (out_fire),
    .cnt   (instret)
  );
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Directed self-checking bench for ysyx_25030093_wbu.
module tb_ysyx_25030093_wbu;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rd_data, csr_wdata, next_pc;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
`ifdef YSYX_25030093_WBU_INSTRET_EN
  logic [63:0] instret;
`endif

  int errs;
  int checks;
  int gw_cnt;
  int ov_cnt;

  ysyx_25030093_wbu dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_data   (rd_data),
    .csr_wdata (csr_wdata),
    .next_pc   (next_pc),
    .rd_addr   (rd_addr),
    .rd_wen    (rd_wen),
    .csr_addr  (csr_addr),
    .csr_wen   (csr_wen),
    .gpr_wen   (gpr_wen),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wdat  (csr_wdat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out)
`ifdef YSYX_25030093_WBU_INSTRET_EN
    ,
    .instret   (instret)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic rw,
                       input logic [31:0] rdat, input logic [11:0] ca,
                       input logic cw, input logic [31:0] cdat,
                       input logic [31:0] npc);
    in_valid  = v;
    rd_addr   = ra;
    rd_wen    = rw;
    rd_data   = rdat;
    csr_addr  = ca;
    csr_wen   = cw;
    csr_wdata = cdat;
    next_pc   = npc;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 12'h0, 1'b0, 32'h0, 32'h0);
    #1;
    // Reset state
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_gpr_wen",   64'(gpr_wen),   64'd0);
    check("rst_csr_we",    64'(csr_we),    64'd0);
    check("rst_pc_out",    64'(pc_out),    64'd0);
    check("rst_gpr_wdata", 64'(gpr_wdata), 64'd0);
    step();
    step();
    reset = 1'b1;

    // Normal GPR write to x5
    drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 12'h0, 1'b0, 32'h0, 32'h80000004);
    step();
    drive(1'b0, 5'd9, 1'b1, 32'h11111111, 12'h7FF, 1'b1, 32'h22222222, 32'h33333333);
    check("t1_gpr_wen",   64'(gpr_wen),   64'd1);
    check("t1_gpr_waddr", 64'(gpr_waddr), 64'd5);
    check("t1_gpr_wdata", 64'(gpr_wdata), 64'hDEADBEEF);
    check("t1_csr_we",    64'(csr_we),    64'd0);
    check("t1_in_ready_w", 64'(in_ready), 64'd0);
    check("t1_ov_w",      64'(out_valid), 64'd0);
    step();
    check("t1_gpr_wen_c", 64'(gpr_wen),   64'd0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_pc_out",    64'(pc_out),    64'h80000004);
    check("t1_in_ready_c", 64'(in_ready), 64'd0);
    step();
    check("t1_in_ready_i", 64'(in_ready), 64'd1);
    check("t1_ov_i",      64'(out_valid), 64'd0);

    // Write to x0 is dropped but the PC still commits
    drive(1'b1, 5'd0, 1'b1, 32'hCAFEF00D, 12'h0, 1'b0, 32'h0, 32'h00000100);
    gw_cnt = 0;
    ov_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 1'b0;
      if (gpr_wen) gw_cnt++;
      if (out_valid) begin
        ov_cnt++;
        check("t2_pc_out", 64'(pc_out), 64'h100);
      end
    end
    check("t2_gpr_wen_cnt", 64'(gw_cnt), 64'd0);
    check("t2_ov_cnt",      64'(ov_cnt), 64'd1);

    // CSR write pulse
    drive(1'b1, 5'd3, 1'b0, 32'h0, 12'h341, 1'b1, 32'h80000010, 32'h00000200);
    step();
    in_valid = 1'b0;
    check("t3_csr_we",    64'(csr_we),    64'd1);
    check("t3_csr_waddr", 64'(csr_waddr), 64'h341);
    check("t3_csr_wdat",  64'(csr_wdat),  64'h80000010);
    check("t3_gpr_wen",   64'(gpr_wen),   64'd0);
    step();
    check("t3_csr_we_c",  64'(csr_we),    64'd0);
    check("t3_out_valid", 64'(out_valid), 64'd1);
    step();
    check("t3_idle", 64'(in_ready), 64'd1);

    // Output back-pressure for 5 cycles with ignored input pulses
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 32'h44444444, 12'h0, 1'b0, 32'h0, 32'h00002000);
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(i[0] ? 1'b0 : 1'b1, 5'd6, 1'b1, 32'h66666666, 12'h305, 1'b1,
            32'h77777777, 32'h00000BAD);
      check("t4_out_valid", 64'(out_valid), 64'd1);
      check("t4_pc_out",    64'(pc_out),    64'h2000);
      check("t4_in_ready",  64'(in_ready),  64'd0);
      check("t4_gpr_wen",   64'(gpr_wen),   64'd0);
      step();
    end
    check("t4_out_valid_end", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("t4_idle",       64'(in_ready), 64'd1);
    check("t4_pc_kept",    64'(pc_out),   64'h2000);
    check("t4_waddr_kept", 64'(gpr_waddr), 64'd4);

    // Reset in the middle of WRITE abandons the result
    drive(1'b1, 5'd7, 1'b1, 32'h12345678, 12'h300, 1'b1, 32'h9, 32'h00003000);
    step();
    in_valid = 1'b0;
    check("t5_gpr_wen_w", 64'(gpr_wen), 64'd1);
    reset = 1'b0;
    #1;
    check("t5_gpr_wen_rst",  64'(gpr_wen),   64'd0);
    check("t5_csr_we_rst",   64'(csr_we),    64'd0);
    check("t5_in_ready_rst", 64'(in_ready),  64'd1);
    check("t5_pc_rst",       64'(pc_out),    64'd0);
    check("t5_waddr_rst",    64'(gpr_waddr), 64'd0);
    step();
    reset = 1'b1;
    gw_cnt = 0;
    ov_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (gpr_wen | csr_we) gw_cnt++;
      if (out_valid) ov_cnt++;
    end
    check("t5_no_write", 64'(gw_cnt), 64'd0);
    check("t5_no_ov",    64'(ov_cnt), 64'd0);
    check("t5_idle",     64'(in_ready), 64'd1);

`ifdef YSYX_25030093_WBU_INSTRET_EN
    // Retire counter: 10 back-to-back results, then wrap
    reset = 1'b0;
    #1;
    check("t6_instret_rst", instret, 64'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 5'd1, 1'b1, 32'h1, 12'h0, 1'b0, 32'h0, 32'h4);
    for (int i = 0; i < 30; i++) step();
    in_valid = 1'b0;
    check("t6_instret_10", instret, 64'd10);
    force dut.u_instret.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_instret.cnt_q;
    check("t6_instret_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t6_instret_wrap", instret, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
